// File: rtl/brisc_pkg.sv
// Shared types for the main-memory model: request opcodes, access sizes,
// controller states, and the helpers that place partial-store data in a word.
package brisc_pkg;

  typedef enum logic [1:0] {
    READ_LINE  = 2'd0,
    WRITE_LINE = 2'd1,
    WRITE_PART = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_e;

  // Copy the low bytes of a store into every lane they could land in, so the
  // byte enables alone pick the destination.
  function automatic logic [31:0] replicate_word(mem_size_e size, logic [31:0] word);
    case (size)
      BYTE:    return {4{word[7:0]}};
      HALF:    return {2{word[15:0]}};
      default: return word;
    endcase
  endfunction

  // Byte lanes touched inside one 32-bit word; misaligned low bits are dropped.
  function automatic logic [3:0] lane_mask(mem_size_e size, logic [1:0] lane);
    case (size)
      BYTE:    return 4'b0001 << lane;
      HALF:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// LINES x LINE_WIDTH storage: byte-masked synchronous write, combinational
// read, and a synchronous clear of the whole array.
module mem_line_array #(
  parameter int LINE_WIDTH = 128,
  parameter int LINES      = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] waddr,
  input  logic [LINE_WIDTH/8-1:0]  be,
  input  logic [LINE_WIDTH-1:0]    wdata,
  input  logic [$clog2(LINES)-1:0] raddr,
  output logic [LINE_WIDTH-1:0]    rdata
);

  localparam int BYTES = LINE_WIDTH / 8;

  logic [LINE_WIDTH-1:0] mem_q [LINES];

  // NOTE: the array is cleared on reset on purpose, so that every simulation
  // starts from a known zero image; this forces it into flops, not SRAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory behind the caches: one outstanding request,
// valid/ready request and response channels, full-line and partial writes.
module main_memory
  import brisc_pkg::*;
#(
  parameter int LINE_WIDTH    = 128,
  parameter int LINES         = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LATENCY       = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  mem_op_e                  req_op,
  input  mem_size_e                req_size,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0]    req_line,
  input  logic [31:0]              req_word,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_is_write,
  output logic [LINE_WIDTH-1:0]    resp_line
);

  localparam int BYTES = LINE_WIDTH / 8;
  localparam int WORDS = LINE_WIDTH / 32;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  mem_op_e               op_q, op_d;
  mem_size_e             size_q, size_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [31:0]           word_q, word_d;
  logic [LINE_WIDTH-1:0] resp_line_q, resp_line_d;
  logic                  resp_is_write_q, resp_is_write_d;

  logic                  commit;
  logic                  op_is_write;
  logic                  arr_we;
  logic [BYTES-1:0]      arr_be;
  logic [BYTES-1:0]      part_be;
  logic [LINE_WIDTH-1:0] arr_wdata;
  logic [LINE_WIDTH-1:0] rd_line;
  logic                  unused_addr_bits;

  // Address bits above the memory size only alias, so they are deliberately dropped.
  assign unused_addr_bits = ^req_addr[ADDRESS_WIDTH-1:OFF_W+IDX_W];

  // Opcode 3 is not a write, so it falls through as a line read.
  assign op_is_write = (op_q == WRITE_LINE) || (op_q == WRITE_PART);

  always_comb begin
    part_be = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (OFF_W'(w) == (off_q >> 2)) part_be[4*w +: 4] = lane_mask(size_q, off_q[1:0]);
    end
  end

  assign arr_we    = commit && op_is_write;
  assign arr_be    = (op_q == WRITE_LINE) ? '1 : part_be;
  assign arr_wdata = (op_q == WRITE_LINE) ? line_q : {WORDS{replicate_word(size_q, word_q)}};

  mem_line_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .LINES      (LINES)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (arr_we),
    .waddr   (idx_q),
    .be      (arr_be),
    .wdata   (arr_wdata),
    .raddr   (idx_q),
    .rdata   (rd_line)
  );

  // NOTE: every signal gets its hold value first, so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    size_d          = size_q;
    off_d           = off_q;
    idx_d           = idx_q;
    line_d          = line_q;
    word_d          = word_q;
    resp_line_d     = resp_line_q;
    resp_is_write_d = resp_is_write_q;
    commit          = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          size_d  = req_size;
          off_d   = req_addr[OFF_W-1:0];
          idx_d   = req_addr[OFF_W +: IDX_W];
          line_d  = req_line;
          word_d  = req_word;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit          = 1'b1;
          resp_is_write_d = op_is_write;
          if (!op_is_write) resp_line_d = rd_line;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      op_q            <= READ_LINE;
      size_q          <= BYTE;
      off_q           <= '0;
      idx_q           <= '0;
      line_q          <= '0;
      word_q          <= '0;
      resp_line_q     <= '0;
      resp_is_write_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      size_q          <= size_d;
      off_q           <= off_d;
      idx_q           <= idx_d;
      line_q          <= line_d;
      word_q          <= word_d;
      resp_line_q     <= resp_line_d;
      resp_is_write_q <= resp_is_write_d;
    end
  end

  assign req_ready     = reset_n && (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_is_write = resp_is_write_q;
  assign resp_line     = resp_line_q;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: vector table through a response
// scoreboard, plus hand sequences for back-pressure, reset and LATENCY = 1.
module tb_main_memory;
  import brisc_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, resp_valid, resp_ready, resp_is_write;
  mem_op_e      req_op;
  mem_size_e    req_size;
  logic [31:0]  req_addr, req_word;
  logic [127:0] req_line, resp_line;

  logic         l1_req_valid, l1_req_ready, l1_resp_valid, l1_resp_ready, l1_resp_is_write;
  mem_op_e      l1_req_op;
  mem_size_e    l1_req_size;
  logic [31:0]  l1_req_addr, l1_req_word;
  logic [127:0] l1_req_line, l1_resp_line;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic         is_write;
    logic         chk_line;
    logic [127:0] line;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string        name;
    mem_op_e      op;
    mem_size_e    size;
    logic [31:0]  addr;
    logic [127:0] line;
    logic [31:0]  word;
    logic         exp_wr;
    logic         chk_line;
    logic [127:0] exp_line;
  } vec_t;
  vec_t vecs[$];

  localparam logic [127:0] L1     = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] L1_B15 = 128'h5523456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] PART   = 128'h00000000DEADBEEFBEEF0000AA000000;
  localparam logic [127:0] L31    = 128'hCAFEF00D112233445566778899AABBCC;

  main_memory #(.LINE_WIDTH(128), .LINES(32), .ADDRESS_WIDTH(32), .LATENCY(5)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_size(req_size), .req_addr(req_addr), .req_line(req_line),
    .req_word(req_word), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_is_write(resp_is_write), .resp_line(resp_line)
  );

  main_memory #(.LINE_WIDTH(128), .LINES(32), .ADDRESS_WIDTH(32), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_op(l1_req_op), .req_size(l1_req_size), .req_addr(l1_req_addr), .req_line(l1_req_line),
    .req_word(l1_req_word), .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
    .resp_is_write(l1_resp_is_write), .resp_line(l1_resp_line)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the accept edge.
  task automatic send(input string nm, input mem_op_e op, input mem_size_e sz,
                      input logic [31:0] a, input logic [127:0] ln, input logic [31:0] w);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check({nm, "_ready"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_op = op; req_size = sz; req_addr = a; req_line = ln; req_word = w;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom; req_word = $urandom;
    req_line  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Waits for the response, checks its latency and pops the scoreboard;
  // completes the handshake only if resp_ready is high.
  task automatic collect(input string nm, input int lat);
    int   c = 0;
    exp_t e;
    while (!resp_valid && c < 50) begin tick(); c++; end
    check({nm, "_latency"}, 128'(c), 128'(lat));
    check({nm, "_req_ready_in_resp"}, 128'(req_ready), 128'(0));
    if (sb.size() == 0) begin
      check({nm, "_scoreboard_empty"}, 128'(0), 128'(1));
    end else begin
      e = sb.pop_front();
      check({nm, "_is_write"}, 128'(resp_is_write), 128'(e.is_write));
      if (e.chk_line) check({nm, "_line"}, resp_line, e.line);
    end
    if (resp_ready) tick();
  endtask

  task automatic run_vec(input vec_t v);
    sb.push_back('{is_write: v.exp_wr, chk_line: v.chk_line, line: v.exp_line});
    send(v.name, v.op, v.size, v.addr, v.line, v.word);
    collect(v.name, 5);
  endtask

  initial begin
    logic [127:0] snap;
    logic         ok;

    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_op = READ_LINE; req_size = BYTE; req_addr = '0; req_line = '0; req_word = '0;
    l1_req_valid = 1'b0; l1_resp_ready = 1'b1;
    l1_req_op = READ_LINE; l1_req_size = BYTE; l1_req_addr = '0; l1_req_line = '0; l1_req_word = '0;

    vecs.push_back('{"rd_after_reset", READ_LINE, BYTE, 32'h40, '0, 0, 1'b0, 1'b1, '0});
    vecs.push_back('{"wr_line", WRITE_LINE, BYTE, 32'h10, L1, 0, 1'b1, 1'b0, '0});
    vecs.push_back('{"rd_offset_ignored", READ_LINE, BYTE, 32'h1C, '0, 0, 1'b0, 1'b1, L1});
    vecs.push_back('{"wr_byte", WRITE_PART, BYTE, 32'h23, '0, 32'h000000AA, 1'b1, 1'b0, '0});
    vecs.push_back('{"wr_half", WRITE_PART, HALF, 32'h26, '0, 32'hFFFFBEEF, 1'b1, 1'b0, '0});
    vecs.push_back('{"wr_word_misaligned", WRITE_PART, WORD, 32'h2B, '0, 32'hDEADBEEF, 1'b1, 1'b0, '0});
    vecs.push_back('{"rd_partial", READ_LINE, BYTE, 32'h20, '0, 0, 1'b0, 1'b1, PART});
    vecs.push_back('{"rd_wrap", READ_LINE, BYTE, 32'h210, '0, 0, 1'b0, 1'b1, L1});
    vecs.push_back('{"op3_as_read", mem_op_e'(2'd3), BYTE, 32'h14, '0, 0, 1'b0, 1'b1, L1});
    vecs.push_back('{"wr_byte_top", WRITE_PART, BYTE, 32'h1F, '0, 32'h12345655, 1'b1, 1'b0, '0});
    vecs.push_back('{"rd_byte_top", READ_LINE, BYTE, 32'h10, '0, 0, 1'b0, 1'b1, L1_B15});
    vecs.push_back('{"wr_last_line", WRITE_LINE, BYTE, 32'h1F0, L31, 0, 1'b1, 1'b0, '0});
    vecs.push_back('{"rd_last_line_wrap", READ_LINE, BYTE, 32'hFFFF_FFF8, '0, 0, 1'b0, 1'b1, L31});

    // Reset held for two edges: outputs quiet, then ready immediately after release.
    tick();
    check("reset_req_ready_low", 128'(req_ready), 128'(0));
    tick();
    check("reset_resp_valid", 128'(resp_valid), 128'(0));
    check("reset_resp_is_write", 128'(resp_is_write), 128'(0));
    check("reset_resp_line", resp_line, '0);
    reset_n = 1'b1;
    tick();
    check("post_reset_req_ready", 128'(req_ready), 128'(1));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: held response, with requests offered during BUSY and RESP.
    resp_ready = 1'b0;
    sb.push_back('{is_write: 1'b0, chk_line: 1'b1, line: PART});
    send("bp_read", READ_LINE, BYTE, 32'h20, '0, 0);
    req_valid = 1'b1; req_op = WRITE_LINE; req_addr = 32'h20; req_line = '1;
    collect("bp_read", 5);
    snap = resp_line;
    ok   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(resp_valid && !req_ready && resp_line === snap)) ok = 1'b0;
    end
    check("bp_stable", 128'(ok), 128'(1));
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("bp_release_ready", 128'(req_ready), 128'(1));
    run_vec('{"rd_after_ignored_req", READ_LINE, BYTE, 32'h20, '0, 0, 1'b0, 1'b1, PART});

    // Reset at T+3 of a line write: no response, write dropped, array cleared.
    send("mid_reset_wr", WRITE_LINE, BYTE, 32'h30, '1, 0);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("mid_reset_ready_low", 128'(req_ready), 128'(0));
    tick();
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) ok = 1'b0;
      tick();
    end
    check("mid_reset_no_resp", 128'(ok), 128'(1));
    run_vec('{"rd_dropped_write", READ_LINE, BYTE, 32'h30, '0, 0, 1'b0, 1'b1, '0});
    run_vec('{"rd_cleared_line", READ_LINE, BYTE, 32'h10, '0, 0, 1'b0, 1'b1, '0});

    // LATENCY = 1: back-to-back with req_valid held high and resp_ready high.
    l1_req_valid = 1'b1; l1_req_op = WRITE_LINE; l1_req_addr = 32'h50; l1_req_line = L31;
    check("l1_ready_before", 128'(l1_req_ready), 128'(1));
    tick();
    l1_req_op = READ_LINE; l1_req_line = '0;
    check("l1_busy_not_ready", 128'(l1_req_ready), 128'(0));
    tick();
    check("l1_resp_at_t1", 128'(l1_resp_valid), 128'(1));
    check("l1_resp_is_write", 128'(l1_resp_is_write), 128'(1));
    tick();
    check("l1_idle_at_t2", 128'(l1_req_ready), 128'(1));
    check("l1_resp_dropped_t2", 128'(l1_resp_valid), 128'(0));
    tick();
    l1_req_valid = 1'b0;
    check("l1_accept_at_t3", 128'(l1_req_ready), 128'(0));
    tick();
    check("l1_rd_resp_valid", 128'(l1_resp_valid), 128'(1));
    check("l1_rd_is_write", 128'(l1_resp_is_write), 128'(0));
    check("l1_rd_line", l1_resp_line, L31);
    tick();

    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
